// File: rtl/levitation_pkg.sv
// Shared constants and types for the levitation host command parser.
package levitation_pkg;

  localparam logic [7:0] SOF_BYTE = 8'hFF;
  localparam logic [7:0] EOF_BYTE = 8'h3C;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  localparam logic [7:0] CMD_LEFT  = 8'h41;
  localparam logic [7:0] CMD_RIGHT = 8'h44;
  localparam logic [7:0] CMD_UP    = 8'h57;
  localparam logic [7:0] CMD_DOWN  = 8'h53;

  // The 4x4 window slides over the 8x8 transducer array.
  localparam int ARRAY_N   = 8;
  localparam int WIN_N     = 4;
  localparam int POS_MAX   = ARRAY_N - WIN_N;
  localparam int POS_RESET = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GET_CMD,
    ST_GET_PHASE,
    ST_GET_EOF
  } state_e;

endpackage

// File: rtl/sat_step.sv
// 3-bit saturating step: increments up to max_i, decrements down to 0, never wraps.
// Purely combinational; increment has priority if both requests are raised.
module sat_step (
  input  logic [2:0] val_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic [2:0] max_i,
  output logic [2:0] val_o
);

  always_comb begin
    val_o = val_i;
    if (inc_i) begin
      if (val_i < max_i) val_o = val_i + 3'd1;
    end else if (dec_i) begin
      if (val_i != 3'd0) val_o = val_i - 3'd1;
    end
  end

endmodule

// File: rtl/levitation_cmd_parser.sv
// Parses FF/CMD/PHASE/3C host frames into window origin and phase delay; outputs move on the EOF edge.
// Replies ACK/NAK through a one-entry buffer that the newest status overwrites; a stalled frame times out.
module levitation_cmd_parser
  import levitation_pkg::*;
#(
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [2:0] win_x,
  output logic [2:0] win_y,
  output logic [9:0] phase_delay,
  output logic       cmd_update,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  state_e      state_q;
  logic [7:0]  cmd_q;
  logic [7:0]  phase_q;
  logic [TW-1:0] cnt_q;
  logic [2:0]  win_x_q, win_y_q;
  logic [2:0]  win_x_d, win_y_d;
  logic [9:0]  phase_delay_q;
  logic        cmd_update_q, frame_err_q, busy_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic        timeout;

  sat_step u_step_x (
    .val_i (win_x_q),
    .inc_i (cmd_q == CMD_RIGHT),
    .dec_i (cmd_q == CMD_LEFT),
    .max_i (3'(POS_MAX)),
    .val_o (win_x_d)
  );

  sat_step u_step_y (
    .val_i (win_y_q),
    .inc_i (cmd_q == CMD_DOWN),
    .dec_i (cmd_q == CMD_UP),
    .max_i (3'(POS_MAX)),
    .val_o (win_y_d)
  );

  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout = (state_q != ST_IDLE) && !rx_valid && (cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cmd_q         <= 8'h00;
      phase_q       <= 8'h00;
      cnt_q         <= '0;
      win_x_q       <= 3'(POS_RESET);
      win_y_q       <= 3'(POS_RESET);
      phase_delay_q <= 10'd0;
      cmd_update_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
    end else begin
      cmd_update_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (tx_valid_q && tx_ready) tx_valid_q <= 1'b0;

      if (state_q == ST_IDLE || rx_valid || timeout) cnt_q <= '0;
      else                                           cnt_q <= cnt_q + TW'(1);

      case (state_q)
        ST_IDLE: begin
          if (rx_valid && rx_data == SOF_BYTE) begin
            state_q <= ST_GET_CMD;
            busy_q  <= 1'b1;
          end
        end
        ST_GET_CMD: begin
          if (rx_valid) begin
            cmd_q   <= rx_data;
            state_q <= ST_GET_PHASE;
          end
        end
        ST_GET_PHASE: begin
          if (rx_valid) begin
            phase_q <= rx_data;
            state_q <= ST_GET_EOF;
          end
        end
        ST_GET_EOF: begin
          if (rx_valid) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            tx_valid_q <= 1'b1;
            if (rx_data == EOF_BYTE) begin
              win_x_q       <= win_x_d;
              win_y_q       <= win_y_d;
              phase_delay_q <= {phase_q, 2'b00};
              cmd_update_q  <= 1'b1;
              tx_data_q     <= ACK_BYTE;
            end else begin
              frame_err_q <= 1'b1;
              tx_data_q   <= NAK_BYTE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (timeout) begin
        state_q     <= ST_IDLE;
        busy_q      <= 1'b0;
        frame_err_q <= 1'b1;
        tx_valid_q  <= 1'b1;
        tx_data_q   <= NAK_BYTE;
      end
    end
  end

  assign win_x       = win_x_q;
  assign win_y       = win_y_q;
  assign phase_delay = phase_delay_q;
  assign cmd_update  = cmd_update_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;

endmodule
